mips16_run_ctrl: RTL and testbench
==================================

Name: mips16_run_ctrl

Overview:
Run/step/halt sequencer for the 16-bit single-cycle MIPS core (mips). It owns the core's reset and clock-enable, and accepts host commands over a valid/ready port. It halts the core on a PC breakpoint and keeps a executed-instruction counter and last ALU result for debug. It sits between the top level/bench and the mips instance.

Parameters:
CYC_W, 32, width of executed-instruction counter
RST_CYCLES, 2, cycles cpu_reset is held on power-up/RESTART (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 RESTART, 5 SET_BP, 6 CLR_BP, 7 SET_LIMIT
cmd_arg  in  16  operand for SET_BP/SET_LIMIT
pc_out  in  16  core PC (registered inside core)
alu_result  in  16  core ALU result
cpu_reset  out  1  drives core reset
cpu_en  out  1  core clock-enable; one instruction retires per cycle high
running  out  1  1 in RUN or STEP
halt_cause  out  2  0 host/none, 1 breakpoint, 2 cycle limit
cycle_count  out  CYC_W  instructions executed since last RESTART
last_alu  out  16  alu_result sampled on last cpu_en cycle

Behaviour:
- States: S_RST, S_HALT, S_RUN, S_STEP. Reset: state S_RST, rst_cnt=RST_CYCLES-1, bp_addr=0, bp_armed=0, skip_bp=0, cycle_count=0, last_alu=0, halt_cause=0.
- S_RST: cpu_reset=1, cpu_en=0, cmd_ready=0. Decrement rst_cnt; at 0 go S_HALT next cycle. cpu_reset is high for exactly RST_CYCLES cycles.
- S_HALT: cpu_reset=0, cpu_en=0, cmd_ready=1. RUN -> S_RUN, skip_bp=1, halt_cause=0. STEP -> S_STEP, halt_cause=0. RESTART -> S_RST. HALT/NOP: no effect.
- S_RUN: cmd_ready=1. bp_match = bp_armed & (pc_out==bp_addr) & !skip_bp. cpu_en = !bp_match (combinational; pc_out is a register so no loop). On bp_match: cpu_en=0 that cycle, go S_HALT, halt_cause=1. skip_bp clears after the first S_RUN cycle, so resuming from a breakpoint PC executes that instruction. HALT cmd: that cycle still has cpu_en per rule above, then S_HALT, cause 0. RESTART -> S_RST. RUN/STEP: ignored.
- S_STEP: cpu_en=1 for exactly one cycle, breakpoints ignored, cmd_ready=0; next state S_HALT.
- SET_BP/CLR_BP accepted in S_HALT and S_RUN: bp_addr<=cmd_arg, bp_armed<=1 / bp_armed<=0. Effective from next cycle.
- If a command and a breakpoint occur in the same cycle in S_RUN: the breakpoint halts. RESTART overrides the breakpoint. SET_BP/CLR_BP are still applied.
- cycle_count increments on every cycle with cpu_en=1 and saturates at all-ones. It clears on entry to S_RST. last_alu<=alu_result on every cpu_en cycle.
- running = (state==S_RUN)|(state==S_STEP). cpu_en=0 whenever cpu_reset=1.
- Reset asserted mid-RUN/STEP: next cycle state S_RST, bp cleared, counters cleared.
- Unused op values and op 7 (without the feature): accepted, no-op.

Optional Feature:
MIPS16_RUN_CYCLE_LIMIT_EN: adds a CYC_W-bit limit register, reset to 0, where 0 means disabled. SET_LIMIT loads zero-extended cmd_arg in S_HALT/S_RUN. In S_RUN, when limit!=0 and cycle_count==limit, cpu_en=0, the state goes to S_HALT with halt_cause=2; this check takes priority over a breakpoint in the same cycle. Without the macro: op 7 is a no-op and halt_cause never equals 2.

Test Plan:
- Reset 2 cycles -> cpu_reset high exactly 2 cycles after reset drops, then S_HALT, cmd_ready=1, cpu_en=0, cycle_count=0.
- STEP x3 from S_HALT -> three single cpu_en pulses, cycle_count=3, last_alu equals alu_result of third pulse, running low after each.
- SET_BP 0x0008 then RUN, core PC increments by 2 -> cpu_en drops in the cycle pc_out==0x0008, halt_cause=1, cycle_count=4. RUN again -> the instruction at 0x0008 executes, no re-hit.
- HALT during S_RUN at cycle_count=10 -> count 11 (issue cycle retires), S_HALT, cause 0. RESTART -> cpu_reset 2 cycles, count 0, bp still armed.
- Reset asserted mid-RUN -> next cycle S_RST, bp_armed=0, cycle_count=0. Simultaneous bp_match+RESTART -> S_RST.
- With MIPS16_RUN_CYCLE_LIMIT_EN: SET_LIMIT 5, RUN from count 0 -> exactly 5 cpu_en cycles, halt_cause=2. Without the macro -> op 7 has no effect.

Source files
------------

// File: rtl/mips16_run_ctrl.sv
// rtl/mips16_run_ctrl.sv - run/step/halt sequencer for the 16-bit single-cycle MIPS core
//
// Owns the core reset and clock-enable, takes host commands over a
// valid/ready port, halts on a PC breakpoint and keeps debug counters.
//
// Optional feature: define MIPS16_RUN_CYCLE_LIMIT_EN to add a cycle-limit
// register (SET_LIMIT, halt_cause 2). Without it op 7 is a no-op.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   host command handshake (accepted when both high)
//   cmd_op, cmd_arg       command opcode and operand
//   pc_out, alu_result    observed core PC and ALU result
//   cpu_reset, cpu_en     core reset and clock-enable
//   running               high in RUN or STEP
//   halt_cause            0 host/none, 1 breakpoint, 2 cycle limit
//   cycle_count           instructions retired since last RESTART
//   last_alu              alu_result sampled on the last cpu_en cycle

module mips16_run_ctrl #(
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [15:0]      cmd_arg,
  input  logic [15:0]      pc_out,
  input  logic [15:0]      alu_result,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic [1:0]       halt_cause,
  output logic [CYC_W-1:0] cycle_count,
  output logic [15:0]      last_alu
);

  typedef enum logic [1:0] {S_RST, S_HALT, S_RUN, S_STEP} state_t;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_HALT    = 3'd3;
  localparam logic [2:0] OP_RESTART = 3'd4;
  localparam logic [2:0] OP_SET_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_BP  = 3'd6;

  localparam int            RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES - 1);

  state_t             state_q, state_d;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [15:0]        bp_addr_q, bp_addr_d;
  logic               bp_armed_q, bp_armed_d;
  logic               skip_bp_q, skip_bp_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;
  logic [15:0]        last_alu_q, last_alu_d;
  logic [1:0]         halt_cause_q, halt_cause_d;
  logic               cmd_fire;
  logic               bp_match;
  logic               lim_hit;

`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
  localparam logic [2:0] OP_SET_LIMIT = 3'd7;
  logic [CYC_W-1:0] limit_q, limit_d;
`endif

  assign cmd_ready   = (state_q == S_HALT) || (state_q == S_RUN);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign running     = (state_q == S_RUN) || (state_q == S_STEP);
  assign halt_cause  = halt_cause_q;
  assign cycle_count = cycle_count_q;
  assign last_alu    = last_alu_q;

  // pc_out is registered inside the core, so gating cpu_en on it is loop-free.
  assign bp_match = (state_q == S_RUN) && bp_armed_q && (pc_out == bp_addr_q) && !skip_bp_q;

`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
  assign lim_hit = (state_q == S_RUN) && (limit_q != '0) && (cycle_count_q == limit_q);
`else
  assign lim_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    bp_addr_d     = bp_addr_q;
    bp_armed_d    = bp_armed_q;
    skip_bp_d     = skip_bp_q;
    cycle_count_d = cycle_count_q;
    last_alu_d    = last_alu_q;
    halt_cause_d  = halt_cause_q;
    cpu_reset     = 1'b0;
    cpu_en        = 1'b0;
`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
    limit_d       = limit_q;
`endif

    case (state_q)
      S_RST: begin
        cpu_reset = 1'b1;
        if (rst_cnt_q == '0) state_d = S_HALT;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      S_HALT: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_RUN: begin
              state_d      = S_RUN;
              skip_bp_d    = 1'b1;   // let the instruction at a breakpoint PC retire on resume
              halt_cause_d = 2'd0;
            end
            OP_STEP: begin
              state_d      = S_STEP;
              halt_cause_d = 2'd0;
            end
            OP_RESTART: state_d = S_RST;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        skip_bp_d = 1'b0;
        cpu_en    = !bp_match && !lim_hit;
        // RESTART beats limit, limit beats breakpoint, breakpoint beats HALT.
        if (cmd_fire && cmd_op == OP_RESTART) begin
          state_d = S_RST;
        end else if (lim_hit) begin
          state_d      = S_HALT;
          halt_cause_d = 2'd2;
        end else if (bp_match) begin
          state_d      = S_HALT;
          halt_cause_d = 2'd1;
        end else if (cmd_fire && cmd_op == OP_HALT) begin
          state_d      = S_HALT;
          halt_cause_d = 2'd0;
        end
      end
      S_STEP: begin
        cpu_en  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase

    if (cmd_fire) begin
      if (cmd_op == OP_SET_BP) begin
        bp_addr_d  = cmd_arg;
        bp_armed_d = 1'b1;
      end
      if (cmd_op == OP_CLR_BP) bp_armed_d = 1'b0;
`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
      if (cmd_op == OP_SET_LIMIT) limit_d = CYC_W'(cmd_arg);
`endif
    end

    if (cpu_en) begin
      last_alu_d = alu_result;
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CYC_W'(1);
    end

    if (state_d == S_RST && state_q != S_RST) begin
      cycle_count_d = '0;
      rst_cnt_d     = RC_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RST;
      rst_cnt_q     <= RC_INIT;
      bp_addr_q     <= '0;
      bp_armed_q    <= 1'b0;
      skip_bp_q     <= 1'b0;
      cycle_count_q <= '0;
      last_alu_q    <= '0;
      halt_cause_q  <= 2'd0;
`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
      limit_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      bp_addr_q     <= bp_addr_d;
      bp_armed_q    <= bp_armed_d;
      skip_bp_q     <= skip_bp_d;
      cycle_count_q <= cycle_count_d;
      last_alu_q    <= last_alu_d;
      halt_cause_q  <= halt_cause_d;
`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
      limit_q       <= limit_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// tb/tb_mips16_run_ctrl.sv - self-checking bench for mips16_run_ctrl

module tb_mips16_run_ctrl;

  localparam int M_RST = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;
  localparam int RSTC  = 2;
`ifdef MIPS16_RUN_CYCLE_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic [15:0] pc_out = 16'd0;
  logic [15:0] alu_result = 16'd0;
  logic        cpu_reset, cpu_en, running;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [15:0] last_alu;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int          m_mode, m_left;
  logic [15:0] m_bp, m_alu;
  bit          m_armed, m_first;
  logic [31:0] m_cnt, m_limit;
  logic [1:0]  m_cause;

  mips16_run_ctrl #(.CYC_W(32), .RST_CYCLES(RSTC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_out(pc_out), .alu_result(alu_result),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .running(running), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .last_alu(last_alu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RST; m_left = RSTC; m_bp = 0; m_armed = 0; m_first = 0;
    m_cnt = 0; m_alu = 0; m_cause = 0; m_limit = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then the core PC.
  task automatic cyc();
    bit rdy, crst, en, hit_bp, hit_lim, fire;
    logic [15:0] pc_nx;
    @(negedge clk);
    rdy     = (m_mode == M_HALT) || (m_mode == M_RUN);
    crst    = (m_mode == M_RST);
    hit_lim = LIM_EN && (m_mode == M_RUN) && (m_limit != 0) && (m_cnt == m_limit);
    hit_bp  = (m_mode == M_RUN) && m_armed && (pc_out == m_bp) && !m_first;
    en      = (m_mode == M_STEP) || ((m_mode == M_RUN) && !hit_lim && !hit_bp);
    fire    = cmd_valid && rdy;
    chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, crst});
    chk("cpu_en", {31'd0, cpu_en}, {31'd0, en});
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, rdy});
    chk("running", {31'd0, running}, {31'd0, (m_mode == M_RUN) || (m_mode == M_STEP)});
    chk("halt_cause", {30'd0, halt_cause}, {30'd0, m_cause});
    chk("cycle_count", cycle_count, m_cnt);
    chk("last_alu", {16'd0, last_alu}, {16'd0, m_alu});
    pc_nx = crst ? 16'd0 : (en ? ((pc_out + 16'd2) & 16'h003E) : pc_out);
    if (reset) begin
      model_reset();
    end else begin
      if (en) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_alu = alu_result;
      end
      case (m_mode)
        M_RST: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_HALT;
        end
        M_HALT: if (fire) begin
          if (cmd_op == 3'd1) begin m_mode = M_RUN; m_first = 1; m_cause = 0; end
          else if (cmd_op == 3'd2) begin m_mode = M_STEP; m_cause = 0; end
          else if (cmd_op == 3'd4) begin m_mode = M_RST; m_left = RSTC; m_cnt = 0; end
        end
        M_RUN: begin
          m_first = 0;
          if (fire && cmd_op == 3'd4) begin m_mode = M_RST; m_left = RSTC; m_cnt = 0; end
          else if (hit_lim) begin m_mode = M_HALT; m_cause = 2; end
          else if (hit_bp) begin m_mode = M_HALT; m_cause = 1; end
          else if (fire && cmd_op == 3'd3) begin m_mode = M_HALT; m_cause = 0; end
        end
        default: m_mode = M_HALT;
      endcase
      if (fire && cmd_op == 3'd5) begin m_bp = cmd_arg; m_armed = 1; end
      if (fire && cmd_op == 3'd6) m_armed = 0;
      if (fire && cmd_op == 3'd7 && LIM_EN) m_limit = {16'd0, cmd_arg};
    end
    @(posedge clk);
    #1;
    pc_out     = pc_nx;
    alu_result = 16'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    cyc();
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  initial begin
    int rc;
    alu_result = 16'h1234;
    @(posedge clk);
    #1;
    model_reset();
    cyc();
    reset = 1'b0;

    // power-up reset length
    rc = 0;
    for (int i = 0; i < 4; i++) begin
      rc += int'(cpu_reset);
      cyc();
    end
    chk("rst_cycles", rc, 2);
    chk("halt_ready", {31'd0, cmd_ready}, 32'd1);
    chk("halt_count0", cycle_count, 32'd0);

    // three single steps
    for (int i = 0; i < 3; i++) begin
      send(3'd2, 16'd0);
      cyc();
      chk("step_running", {31'd0, running}, 32'd0);
    end
    chk("step_count", cycle_count, 32'd3);

    // breakpoint at 0x0008 after a fresh restart
    send(3'd4, 16'd0);
    idle(2);
    send(3'd5, 16'h0008);
    send(3'd1, 16'd0);
    idle(6);
    chk("bp_cause", {30'd0, halt_cause}, 32'd1);
    chk("bp_count", cycle_count, 32'd4);

    // resume from the breakpoint PC, host HALT at count 10
    send(3'd1, 16'd0);
    for (int k = 0; k < 40 && m_cnt != 10; k++) cyc();
    send(3'd3, 16'd0);
    chk("halt_count", cycle_count, 32'd11);
    chk("halt_cause0", {30'd0, halt_cause}, 32'd0);

    // RESTART keeps the breakpoint armed
    send(3'd4, 16'd0);
    idle(2);
    chk("restart_count", cycle_count, 32'd0);
    send(3'd1, 16'd0);
    idle(6);
    chk("bp_rearm_cause", {30'd0, halt_cause}, 32'd1);

    // reset asserted mid-RUN
    send(3'd1, 16'd0);
    idle(2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrun_rst", {31'd0, cpu_reset}, 32'd1);
    chk("midrun_count", cycle_count, 32'd0);
    idle(3);
    send(3'd1, 16'd0);
    idle(8);
    chk("bp_disarmed", {31'd0, running}, 32'd1);
    send(3'd3, 16'd0);

    // breakpoint and RESTART in the same cycle
    send(3'd4, 16'd0);
    idle(2);
    send(3'd5, 16'h0004);
    send(3'd1, 16'd0);
    idle(2);
    send(3'd4, 16'd0);
    chk("bp_restart", {31'd0, cpu_reset}, 32'd1);
    idle(3);

    // cycle limit (op 7)
    send(3'd6, 16'd0);
    send(3'd7, 16'd5);
    send(3'd1, 16'd0);
    idle(8);
    if (LIM_EN) begin
      chk("limit_count", cycle_count, 32'd5);
      chk("limit_cause", {30'd0, halt_cause}, 32'd2);
    end else begin
      chk("nolimit_run", {31'd0, running}, 32'd1);
      chk("nolimit_cause", {30'd0, halt_cause}, 32'd0);
    end
    send(3'd3, 16'd0);
    idle(1);

    // randomized commands against the model
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_arg   = (cmd_op == 3'd7) ? 16'($urandom_range(0, 30)) : 16'($urandom_range(0, 31) * 2);
      cyc();
    end
    reset = 1'b0; cmd_valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
